// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel sequencer.
// Synchronizes and debounces three raw push-buttons, turns debounced presses
// into one-cycle events, and runs the stopwatch state machine that drives the
// counter datapath (Start_S/Stop_S/Reset_S) plus the display mode and lap hold.
//
//   state | meaning
//   IDLE  | counter cleared and stopped, waiting for start
//   RUN   | counter running, lap/reset button toggles display freeze
//   PAUSE | counter stopped, start resumes, lap/reset clears
//   CLEAR | Reset_S/Stop_S held high for CLEAR_CYCLES, then back to IDLE
module stopwatch_ctrl #(
    parameter int DEBOUNCE_MS  = 20,
    parameter int NUM_MODES    = 3,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       Clock_1MSec,
    input  logic       Reset,
    input  logic       Btn_Mode,
    input  logic       Btn_StartStop,
    input  logic       Btn_LapReset,
    output logic       Control,
    output logic [1:0] Mode,
    output logic       Start_S,
    output logic       Stop_S,
    output logic       Reset_S,
    output logic       Lap_Hold,
    output logic [1:0] SW_State
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    // Button index: 0 = mode, 1 = start/stop, 2 = lap/reset
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] db_level;
    logic [2:0] db_level_d;
    logic [2:0] press;

    assign btn_raw = {Btn_LapReset, Btn_StartStop, Btn_Mode};

    // Two-flop synchronizer, previous debounced level and press pulse
    always_ff @(posedge Clock_1MSec or posedge Reset) begin
        if (Reset) begin
            sync1      <= '0;
            sync2      <= '0;
            db_level_d <= '0;
            press      <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            db_level_d <= db_level;
            press      <= db_level & ~db_level_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_debounce
            logic [DW-1:0] db_cnt;

            // Accept a new level only after DEBOUNCE_MS consecutive differing samples
            always_ff @(posedge Clock_1MSec or posedge Reset) begin
                if (Reset) begin
                    db_cnt       <= '0;
                    db_level[gi] <= 1'b0;
                end else if (sync2[gi] != db_level[gi]) begin
                    if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
                        db_level[gi] <= sync2[gi];
                        db_cnt       <= '0;
                    end else if (db_cnt != DW'(DEBOUNCE_MS)) begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt <= '0;
                end
            end
        end
    endgenerate

    logic [1:0]    state;
    logic [CW-1:0] clr_cnt;
    logic          ev_mode;
    logic          ev_ss;
    logic          ev_lr;

    // CLEAR swallows every button; start/stop and lap/reset only act in mode 0.
    // Within a cycle mode wins over start/stop, which wins over lap/reset.
    assign ev_mode = press[0] & (state != S_CLEAR);
    assign ev_ss   = press[1] & ~press[0] & (Mode == 2'd0) & (state != S_CLEAR);
    assign ev_lr   = press[2] & ~press[0] & ~press[1] & (Mode == 2'd0) & (state != S_CLEAR);

    logic [1:0]    nxt_mode;
    logic [1:0]    nxt_state;
    logic [CW-1:0] nxt_clr;
    logic          nxt_start;
    logic          nxt_stop;
    logic          nxt_rst;
    logic          nxt_lap;

    // Display mode rotation
    always_comb begin
        nxt_mode = Mode;
        if (ev_mode) begin
            nxt_mode = (Mode == 2'(NUM_MODES - 1)) ? 2'd0 : Mode + 2'd1;
        end
    end

    // Next state and next registered outputs of the stopwatch FSM
    always_comb begin
        nxt_state = state;
        nxt_clr   = clr_cnt;
        nxt_start = Start_S;
        nxt_stop  = Stop_S;
        nxt_rst   = Reset_S;
        nxt_lap   = Lap_Hold;
        case (state)
            S_IDLE: begin
                if (ev_ss) begin
                    nxt_state = S_RUN;
                    nxt_start = 1'b1;
                    nxt_stop  = 1'b0;
                    nxt_rst   = 1'b0;
                end
            end
            S_RUN: begin
                if (ev_ss) begin
                    nxt_state = S_PAUSE;
                    nxt_start = 1'b0;
                    nxt_stop  = 1'b1;
                end else if (ev_lr) begin
                    nxt_lap = ~Lap_Hold;
                end
            end
            S_PAUSE: begin
                if (ev_ss) begin
                    nxt_state = S_RUN;
                    nxt_start = 1'b1;
                    nxt_stop  = 1'b0;
                    nxt_lap   = 1'b0;
                end else if (ev_lr) begin
                    nxt_state = S_CLEAR;
                    nxt_start = 1'b0;
                    nxt_stop  = 1'b1;
                    nxt_rst   = 1'b1;
                    nxt_lap   = 1'b0;
                    nxt_clr   = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                    nxt_state = S_IDLE;
                    nxt_start = 1'b0;
                    nxt_stop  = 1'b0;
                    nxt_rst   = 1'b0;
                    nxt_lap   = 1'b0;
                    nxt_clr   = '0;
                end else begin
                    nxt_clr = clr_cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_start = 1'b0;
                nxt_stop  = 1'b0;
                nxt_rst   = 1'b0;
                nxt_lap   = 1'b0;
                nxt_clr   = '0;
            end
        endcase
    end

    // State, mode and all outputs registered together
    always_ff @(posedge Clock_1MSec or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            clr_cnt  <= '0;
            Mode     <= 2'd0;
            Control  <= 1'b0;
            Start_S  <= 1'b0;
            Stop_S   <= 1'b0;
            Reset_S  <= 1'b0;
            Lap_Hold <= 1'b0;
        end else begin
            state    <= nxt_state;
            clr_cnt  <= nxt_clr;
            Mode     <= nxt_mode;
            Control  <= (nxt_mode != 2'd0);
            Start_S  <= nxt_start;
            Stop_S   <= nxt_stop;
            Reset_S  <= nxt_rst;
            Lap_Hold <= nxt_lap;
        end
    end

    assign SW_State = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: hand-timed latency and CLEAR dwell
// sequences, a press table walking the FSM and mode logic, plus bounce,
// same-cycle priority and asynchronous reset corner cases.
module tb_stopwatch_ctrl;

    localparam int DEB = 20;

    logic       clk;
    logic       rst;
    logic       btn_m;
    logic       btn_ss;
    logic       btn_lr;
    logic       control;
    logic [1:0] mode;
    logic       start_s;
    logic       stop_s;
    logic       reset_s;
    logic       lap_hold;
    logic [1:0] sw_state;

    int n_chk  = 0;
    int n_fail = 0;

    stopwatch_ctrl #(.DEBOUNCE_MS(DEB), .NUM_MODES(3), .CLEAR_CYCLES(2)) dut (
        .Clock_1MSec  (clk),
        .Reset        (rst),
        .Btn_Mode     (btn_m),
        .Btn_StartStop(btn_ss),
        .Btn_LapReset (btn_lr),
        .Control      (control),
        .Mode         (mode),
        .Start_S      (start_s),
        .Stop_S       (stop_s),
        .Reset_S      (reset_s),
        .Lap_Hold     (lap_hold),
        .SW_State     (sw_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {SW_State, Mode, Control, Start_S, Stop_S, Reset_S, Lap_Hold}
    logic [8:0] obs;
    assign obs = {sw_state, mode, control, start_s, stop_s, reset_s, lap_hold};

    typedef struct packed {
        logic [1:0] btn;   // 0 mode, 1 start/stop, 2 lap/reset
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_m  = v;
            1:       btn_ss = v;
            default: btn_lr = v;
        endcase
    endtask

    // Clean press held 30 cycles, then released long enough to debounce low
    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        repeat (30) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (DEB + 8) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        btn_m  = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", obs, 9'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("after_reset", obs, 9'b0);

        // Start latency: sampled at edge E -> Start_S at E+DEB+3
        @(negedge clk);
        btn_ss = 1'b1;
        @(posedge clk);                   // edge E
        repeat (DEB + 2) @(posedge clk);  // edge E+DEB+2
        #1 chk("start_latency_early", {sw_state, 6'b0, start_s}, 9'b0);
        @(posedge clk);                   // edge E+DEB+3
        #1 chk("start_latency_edge", {sw_state, 6'b0, start_s}, {2'd1, 6'b0, 1'b1});
        repeat (27) @(negedge clk);
        btn_ss = 1'b0;
        repeat (DEB + 8) @(negedge clk);

        press(1);
        chk("second_press_pause", obs, {2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

        // CLEAR dwell: Reset_S/Stop_S high for exactly two cycles
        @(negedge clk);
        btn_lr = 1'b1;
        @(posedge clk);
        repeat (DEB + 2) @(posedge clk);
        #1 chk("clear_before", obs, {2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1 chk("clear_cycle1", obs, {2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1 chk("clear_cycle2", obs, {2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1 chk("clear_done", obs, 9'b0);
        repeat (25) @(negedge clk);
        btn_lr = 1'b0;
        repeat (DEB + 8) @(negedge clk);

        // Bounce shorter than the debounce window produces no event
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            btn_ss = ~btn_ss;
            repeat (4) @(negedge clk);
        end
        btn_ss = 1'b0;
        repeat (40) @(negedge clk);
        chk("bounce_no_event", obs, 9'b0);

        // Press table: {button, expected outputs after the press settles}
        tbl[0]  = {2'd1, 2'd1, 2'd0, 5'b0_1_0_0_0};
        tbl[1]  = {2'd2, 2'd1, 2'd0, 5'b0_1_0_0_1};
        tbl[2]  = {2'd2, 2'd1, 2'd0, 5'b0_1_0_0_0};
        tbl[3]  = {2'd1, 2'd2, 2'd0, 5'b0_0_1_0_0};
        tbl[4]  = {2'd1, 2'd1, 2'd0, 5'b0_1_0_0_0};
        tbl[5]  = {2'd1, 2'd2, 2'd0, 5'b0_0_1_0_0};
        tbl[6]  = {2'd2, 2'd0, 2'd0, 5'b0_0_0_0_0};
        tbl[7]  = {2'd2, 2'd0, 2'd0, 5'b0_0_0_0_0};
        tbl[8]  = {2'd0, 2'd0, 2'd1, 5'b1_0_0_0_0};
        tbl[9]  = {2'd1, 2'd0, 2'd1, 5'b1_0_0_0_0};
        tbl[10] = {2'd0, 2'd0, 2'd2, 5'b1_0_0_0_0};
        tbl[11] = {2'd2, 2'd0, 2'd2, 5'b1_0_0_0_0};
        tbl[12] = {2'd0, 2'd0, 2'd0, 5'b0_0_0_0_0};
        tbl[13] = {2'd1, 2'd1, 2'd0, 5'b0_1_0_0_0};
        tbl[14] = {2'd0, 2'd1, 2'd1, 5'b1_1_0_0_0};
        tbl[15] = {2'd1, 2'd1, 2'd1, 5'b1_1_0_0_0};
        tbl[16] = {2'd0, 2'd1, 2'd2, 5'b1_1_0_0_0};
        tbl[17] = {2'd0, 2'd1, 2'd0, 5'b0_1_0_0_0};
        tbl[18] = {2'd1, 2'd2, 2'd0, 5'b0_0_1_0_0};
        tbl[19] = {2'd2, 2'd0, 2'd0, 5'b0_0_0_0_0};
        for (int i = 0; i < 20; i++) begin
            press(int'(tbl[i].btn));
            chk($sformatf("table_%0d", i), obs, tbl[i].exp);
        end

        // Mode and start/stop debounced on the same edge: mode wins
        @(negedge clk);
        btn_m  = 1'b1;
        btn_ss = 1'b1;
        repeat (30) @(negedge clk);
        btn_m  = 1'b0;
        btn_ss = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        chk("simultaneous_mode_wins", obs, {2'd0, 2'd1, 5'b1_0_0_0_0});

        // Back to mode 0, start, then asynchronous reset mid-cycle
        press(0);
        press(0);
        press(1);
        chk("run_before_reset", obs, {2'd1, 2'd0, 5'b0_1_0_0_0});
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset", obs, 9'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", obs, 9'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
